ps2_key_encoder: RTL and testbench



---
 rtl/ps2_key_encoder.sv | 213 +++++++++++++++++++++
 tb/tb_ps2_key_encoder.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_encoder.sv
// ps2_key_encoder
// Receives device-to-host PS/2 keyboard frames and turns each completed
// make/break event into an 11-bit toggle-event word for key decoders.
//
// Ports:
//   clk          system clock
//   reset_n      asynchronous active-low reset
//   ps2_clk      raw PS/2 clock line (asynchronous)
//   ps2_data     raw PS/2 data line (asynchronous)
//   ps2_key      [10] toggle, [9] pressed, [8] extended, [7:0] scan code
//   byte_strobe  one-cycle pulse per valid received byte
//   byte_data    last valid received byte, held between strobes
//   frame_err    one-cycle pulse on parity or stop-bit error
//
// Frame FSM states:
//   state    | meaning
//   S_IDLE   | waiting for a start bit (data=0 on a falling edge)
//   S_DATA   | shifting in 8 data bits, LSB first
//   S_PARITY | capturing the parity bit
//   S_STOP   | checking stop bit and odd parity, then strobe or error

module ps2_key_encoder #(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 4800
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [10:0] ps2_key,
    output logic        byte_strobe,
    output logic [7:0]  byte_data,
    output logic        frame_err
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_PARITY = 2'd2,
        S_STOP   = 2'd3
    } state_t;

    logic          clk_meta, clk_sync;
    logic          data_meta, data_sync;
    logic          clk_filt;
    logic [FW-1:0] filt_cnt;
    logic          fall;
    logic [TW-1:0] tmo_cnt;
    logic          timeout;

    state_t        state, state_nxt;
    logic [2:0]    bit_cnt, bit_cnt_nxt;
    logic [7:0]    shift, shift_nxt;
    logic          par_bit, par_nxt;
    logic          strobe_nxt, err_nxt;
    logic [7:0]    data_nxt;

    logic          ext, brk;
    logic [2:0]    skip_cnt;
    logic          is_resp;

    // Synchronizers and clock glitch filter. The filtered clock only moves
    // after FILTER_LEN consecutive synchronized samples disagree with it;
    // fall is a registered one-cycle pulse on each filtered 1->0 change.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clk_meta  <= 1'b1;
            clk_sync  <= 1'b1;
            data_meta <= 1'b1;
            data_sync <= 1'b1;
            clk_filt  <= 1'b1;
            filt_cnt  <= '0;
            fall      <= 1'b0;
        end else begin
            clk_meta  <= ps2_clk;
            clk_sync  <= clk_meta;
            data_meta <= ps2_data;
            data_sync <= data_meta;
            fall      <= 1'b0;
            if (clk_sync == clk_filt) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
                clk_filt <= clk_sync;
                filt_cnt <= '0;
                fall     <= ~clk_sync;
            end else begin
                filt_cnt <= filt_cnt + FW'(1);
            end
        end
    end

    // Cycles since the last falling edge; saturates so an idle bus never wraps.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tmo_cnt <= '0;
        end else if (fall) begin
            tmo_cnt <= '0;
        end else if (tmo_cnt != TW'(TIMEOUT)) begin
            tmo_cnt <= tmo_cnt + TW'(1);
        end
    end

    assign timeout = (state != S_IDLE) && (tmo_cnt == TW'(TIMEOUT));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            bit_cnt     <= '0;
            shift       <= '0;
            par_bit     <= 1'b0;
            byte_strobe <= 1'b0;
            frame_err   <= 1'b0;
            byte_data   <= '0;
        end else begin
            state       <= state_nxt;
            bit_cnt     <= bit_cnt_nxt;
            shift       <= shift_nxt;
            par_bit     <= par_nxt;
            byte_strobe <= strobe_nxt;
            frame_err   <= err_nxt;
            byte_data   <= data_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        bit_cnt_nxt = bit_cnt;
        shift_nxt   = shift;
        par_nxt     = par_bit;
        strobe_nxt  = 1'b0;
        err_nxt     = 1'b0;
        data_nxt    = byte_data;
        if (timeout) begin
            // Abandoned partial frame: silently resynchronize.
            state_nxt   = S_IDLE;
            bit_cnt_nxt = '0;
            shift_nxt   = '0;
        end else if (fall) begin
            case (state)
                S_IDLE: begin
                    if (!data_sync) begin
                        state_nxt   = S_DATA;
                        bit_cnt_nxt = '0;
                    end
                end
                S_DATA: begin
                    shift_nxt[bit_cnt] = data_sync;
                    if (bit_cnt == 3'd7) begin
                        state_nxt = S_PARITY;
                    end else begin
                        bit_cnt_nxt = bit_cnt + 3'd1;
                    end
                end
                S_PARITY: begin
                    par_nxt   = data_sync;
                    state_nxt = S_STOP;
                end
                S_STOP: begin
                    if (data_sync && ((^shift) ^ par_bit)) begin
                        strobe_nxt = 1'b1;
                        data_nxt   = shift;
                    end else begin
                        err_nxt = 1'b1;
                    end
                    state_nxt = S_IDLE;
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // Device responses are only meaningful when no prefix is pending.
    assign is_resp = byte_data inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF};

    // Event decoder. A framing error drops any pending prefix and the Pause
    // skip so a damaged multi-byte sequence cannot leak into the next event.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ps2_key  <= '0;
            ext      <= 1'b0;
            brk      <= 1'b0;
            skip_cnt <= '0;
        end else if (frame_err) begin
            ext      <= 1'b0;
            brk      <= 1'b0;
            skip_cnt <= '0;
        end else if (byte_strobe) begin
            if (skip_cnt != 3'd0) begin
                skip_cnt <= skip_cnt - 3'd1;
            end else if (byte_data == 8'hE1) begin
                // Pause: report once as code 0x77 and swallow the other 7 bytes.
                skip_cnt <= 3'd7;
                ps2_key  <= {~ps2_key[10], 1'b1, 1'b0, 8'h77};
                ext      <= 1'b0;
                brk      <= 1'b0;
            end else if (byte_data == 8'hE0) begin
                ext <= 1'b1;
            end else if (byte_data == 8'hF0) begin
                brk <= 1'b1;
            end else if (!ext && !brk && is_resp) begin
                ps2_key <= ps2_key;
            end else begin
                ps2_key <= {~ps2_key[10], ~brk, ext, byte_data};
                ext     <= 1'b0;
                brk     <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ps2_key_encoder.sv
module tb_ps2_key_encoder;

    // Bit half-period in clk cycles; much faster than a real keyboard so the
    // run stays short, but still far longer than the clock filter.
    localparam int HALF    = 20;
    localparam int TIMEOUT = 4800;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        ps2_clk = 1'b1;
    logic        ps2_data = 1'b1;
    logic [10:0] ps2_key;
    logic        byte_strobe;
    logic [7:0]  byte_data;
    logic        frame_err;

    int checks = 0;
    int errors = 0;
    int strobes = 0;
    int errs = 0;
    int events = 0;
    logic prev_tog = 1'b0;

    int s0, e0, v0;

    ps2_key_encoder #(.FILTER_LEN(8), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .ps2_clk     (ps2_clk),
        .ps2_data    (ps2_data),
        .ps2_key     (ps2_key),
        .byte_strobe (byte_strobe),
        .byte_data   (byte_data),
        .frame_err   (frame_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (byte_strobe) strobes++;
        if (frame_err) errs++;
        if (ps2_key[10] !== prev_tog) events++;
        prev_tog = ps2_key[10];
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic ps2_bit(input logic b);
        ps2_data = b;
        repeat (HALF) @(posedge clk);
        ps2_clk = 1'b0;
        repeat (HALF) @(posedge clk);
        ps2_clk = 1'b1;
    endtask

    // Sends the first nbits of a frame: start, 8 data LSB first, odd parity
    // (optionally inverted), stop. Ends with an idle gap and on a negedge.
    task automatic send_frame(input logic [7:0] b, input bit bad_par, input int nbits);
        logic [10:0] f;
        f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) ps2_bit(f[i]);
        ps2_data = 1'b1;
        repeat (2 * HALF) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic snap();
        s0 = strobes;
        e0 = errs;
        v0 = events;
    endtask

    initial begin
        repeat (5) @(negedge clk);
        check_val("rst_key", ps2_key, 11'h000);
        check_val("rst_byte", byte_data, 8'h00);
        check_val("rst_strobe", byte_strobe, 1'b0);
        check_val("rst_err", frame_err, 1'b0);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);

        // A make
        snap();
        send_frame(8'h1C, 0, 11);
        check_val("a_strobes", strobes - s0, 1);
        check_val("a_byte", byte_data, 8'h1C);
        check_val("a_key", ps2_key, 11'h61C);

        // A break
        snap();
        send_frame(8'hF0, 0, 11);
        send_frame(8'h1C, 0, 11);
        check_val("brk_strobes", strobes - s0, 2);
        check_val("brk_events", events - v0, 1);
        check_val("brk_key", ps2_key, 11'h01C);

        // Extended make and break
        send_frame(8'hE0, 0, 11);
        send_frame(8'h75, 0, 11);
        check_val("ext_make_key", ps2_key, 11'h775);
        send_frame(8'hE0, 0, 11);
        send_frame(8'hF0, 0, 11);
        send_frame(8'h75, 0, 11);
        check_val("ext_brk_key", ps2_key, 11'h175);

        // Parity error, then recovery
        snap();
        send_frame(8'h1C, 1, 11);
        check_val("par_errs", errs - e0, 1);
        check_val("par_strobes", strobes - s0, 0);
        check_val("par_key", ps2_key, 11'h175);
        send_frame(8'h16, 0, 11);
        check_val("par_recover_key", ps2_key, 11'h616);

        // Partial frame abandoned by timeout
        snap();
        send_frame(8'h55, 0, 5);
        repeat (TIMEOUT + 10) @(negedge clk);
        send_frame(8'h29, 0, 11);
        check_val("tmo_strobes", strobes - s0, 1);
        check_val("tmo_errs", errs - e0, 0);
        check_val("tmo_byte", byte_data, 8'h29);
        check_val("tmo_key", ps2_key, 11'h229);

        // Pause sequence, then a device response
        snap();
        send_frame(8'hE1, 0, 11);
        send_frame(8'h14, 0, 11);
        send_frame(8'h77, 0, 11);
        send_frame(8'hE1, 0, 11);
        send_frame(8'hF0, 0, 11);
        send_frame(8'h14, 0, 11);
        send_frame(8'hF0, 0, 11);
        send_frame(8'h77, 0, 11);
        check_val("pause_strobes", strobes - s0, 8);
        check_val("pause_events", events - v0, 1);
        check_val("pause_key", ps2_key, 11'h677);
        snap();
        send_frame(8'hAA, 0, 11);
        check_val("resp_byte", byte_data, 8'hAA);
        check_val("resp_events", events - v0, 0);
        check_val("resp_key", ps2_key, 11'h677);

        // Short clock glitch with data low must not start a frame
        snap();
        ps2_data = 1'b0;
        repeat (HALF) @(posedge clk);
        ps2_clk = 1'b0;
        repeat (4) @(posedge clk);
        ps2_clk = 1'b1;
        repeat (HALF) @(posedge clk);
        send_frame(8'h1C, 0, 11);
        check_val("glitch_errs", errs - e0, 0);
        check_val("glitch_byte", byte_data, 8'h1C);
        check_val("glitch_key", ps2_key, 11'h21C);

        // Reset mid-frame
        send_frame(8'h33, 0, 6);
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check_val("midrst_key", ps2_key, 11'h000);
        check_val("midrst_byte", byte_data, 8'h00);
        check_val("midrst_strobe", byte_strobe, 1'b0);
        check_val("midrst_err", frame_err, 1'b0);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        snap();
        ps2_bit(1'b1);
        repeat (2 * HALF) @(negedge clk);
        send_frame(8'h5A, 0, 11);
        check_val("post_rst_strobes", strobes - s0, 1);
        check_val("post_rst_errs", errs - e0, 0);
        check_val("post_rst_key", ps2_key, 11'h65A);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
